// File: rtl/acond_pkg.sv
// acond_pkg
// Shared definitions for the ADC-sample conditioning stage:
//   - FSM state encoding (S_BYPASS / S_ACCUM)
//   - width helpers for the difference and accumulator datapaths
//   - saturation limits for a signed output of a given width
package acond_pkg;

    localparam int STATE_W = 1;

    localparam logic [STATE_W-1:0] S_BYPASS = 1'b0;
    localparam logic [STATE_W-1:0] S_ACCUM  = 1'b1;

    // One extra bit so that in_data - offset can never wrap.
    function automatic int diff_w(input int data_w);
        return data_w + 1;
    endfunction

    // Room for 2^avg_log2 differences summed without overflow.
    function automatic int acc_w(input int data_w, input int avg_log2);
        return data_w + 1 + avg_log2;
    endfunction

    // Largest value representable in a signed out_w-bit number.
    function automatic logic signed [63:0] sat_max(input int out_w);
        return (64'sd1 <<< (out_w - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a signed out_w-bit number.
    function automatic logic signed [63:0] sat_min(input int out_w);
        return -(64'sd1 <<< (out_w - 1));
    endfunction

endpackage

// File: rtl/acond_sat.sv
// acond_sat
// Combinational signed saturator from IN_W to OUT_W bits.
// Ports:
//   in_val  - signed input value (IN_W bits)
//   out_val - signed result, sign-extended or clamped to OUT_W bits
//   ovf     - high when the input was outside the OUT_W range and got clamped
module acond_sat
    import acond_pkg::*;
#(
    parameter int IN_W  = 14,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  in_val,
    output logic signed [OUT_W-1:0] out_val,
    output logic                    ovf
);

    generate
        if (IN_W <= OUT_W) begin : g_extend
            // Widening can never overflow, so a plain sign extension suffices.
            assign out_val = OUT_W'(in_val);
            assign ovf     = 1'b0;
        end else begin : g_clamp
            localparam logic signed [63:0] HI = sat_max(OUT_W);
            localparam logic signed [63:0] LO = sat_min(OUT_W);

            logic signed [63:0] in_ext;

            assign in_ext = 64'(in_val);

            always_comb begin
                out_val = in_val[OUT_W-1:0];
                ovf     = 1'b0;
                if (in_ext > HI) begin
                    out_val = HI[OUT_W-1:0];
                    ovf     = 1'b1;
                end else if (in_ext < LO) begin
                    out_val = LO[OUT_W-1:0];
                    ovf     = 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/acond_signal_stage.sv
// acond_signal_stage
// Streaming ADC-sample conditioning stage. With acond_en low, samples pass
// straight through (sign-extended or saturated to OUT_W). With acond_en high,
// the offset is removed, blocks of 2^AVG_LOG2 samples are averaged (floor)
// and one saturated average is emitted per block.
// Ports:
//   clk          - system clock, rising edge
//   reset_n      - asynchronous active-low reset
//   acond_en     - conditioning enable, sampled together with in_valid
//   offset       - signed offset subtracted in conditioned mode
//   in_data      - signed input sample
//   in_valid     - input sample strobe
//   out_data     - signed output sample
//   out_valid    - single-cycle output strobe
//   acond_active - high while the FSM is in S_ACCUM
//   sat_flag     - sticky flag, set whenever an output saturates
module acond_signal_stage
    import acond_pkg::*;
#(
    parameter int DATA_W   = 14,
    parameter int OUT_W    = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     acond_en,
    input  logic signed [DATA_W-1:0] offset,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    output logic                     acond_active,
    output logic                     sat_flag
);

    localparam int DIFF_W = diff_w(DATA_W);
    localparam int ACC_W  = acc_w(DATA_W, AVG_LOG2);

    localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;

    logic [STATE_W-1:0]       state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [AVG_LOG2-1:0]      cnt_q, cnt_d;
    logic signed [OUT_W-1:0]  out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     sat_q, sat_d;

    logic signed [DIFF_W-1:0] diff;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  avg;
    logic signed [OUT_W-1:0]  byp_data;
    logic                     byp_ovf;
    logic signed [OUT_W-1:0]  avg_data;
    logic                     avg_ovf;

    assign diff = DIFF_W'(in_data) - DIFF_W'(offset);
    assign sum  = acc_q + ACC_W'(diff);
    // Arithmetic shift floors toward -inf, so -1/4 becomes -1 rather than 0.
    assign avg  = sum >>> AVG_LOG2;

    acond_sat #(
        .IN_W  (DATA_W),
        .OUT_W (OUT_W)
    ) u_byp_sat (
        .in_val  (in_data),
        .out_val (byp_data),
        .ovf     (byp_ovf)
    );

    acond_sat #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_W)
    ) u_avg_sat (
        .in_val  (avg),
        .out_val (avg_data),
        .ovf     (avg_ovf)
    );

    // acc and cnt are always zero while in bypass, so a sample arriving with
    // acond_en high is the first of a block whether or not the FSM was
    // already in S_ACCUM. That lets the mode decision depend on acond_en only.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        sat_d       = sat_q;

        if (!acond_en) begin
            // Leaving or staying in bypass always drops any partial block.
            state_d = S_BYPASS;
            acc_d   = '0;
            cnt_d   = '0;
            if (in_valid) begin
                out_data_d  = byp_data;
                out_valid_d = 1'b1;
                sat_d       = sat_q | byp_ovf;
            end
        end else begin
            state_d = S_ACCUM;
            if (in_valid) begin
                if (cnt_q == CNT_LAST) begin
                    out_data_d  = avg_data;
                    out_valid_d = 1'b1;
                    sat_d       = sat_q | avg_ovf;
                    acc_d       = '0;
                    cnt_d       = '0;
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_q + AVG_LOG2'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_BYPASS;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign acond_active = (state_q == S_ACCUM);
    assign sat_flag     = sat_q;

endmodule
